// File: rtl/sobel_pkg.sv
// Shared constants and types for the streaming 3x3 Sobel gradient-square stage.
//   GX_W        : width of a raw signed gradient (range +-1020)
//   GS_W        : width of a scaled signed gradient (range +-255)
//   SQ_W        : width of a squared scaled gradient (max 65025)
//   SCALE_SHIFT : arithmetic right shift applied when saturation is not built in
//   SAT_LIM     : clamp magnitude used when SOBEL_SAT_EN is defined
//   state_e     : frame-tracking FSM states
//   SOBEL_K     : 1-D smoothing weights; gx/gy are the weighted difference of
//                 the outer columns/rows of the 3x3 window
package sobel_pkg;

    localparam int GX_W        = 11;
    localparam int GS_W        = 9;
    localparam int SQ_W        = 17;
    localparam int SCALE_SHIFT = 2;
    localparam int SAT_LIM     = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic signed [GX_W-1:0] SOBEL_K [3] = '{GX_W'(1), GX_W'(2), GX_W'(1)};

endpackage

// File: rtl/sobel_line_buf.sv
// One line of pixel storage for the Sobel window.
// Registered read port (data appears the cycle after rd_en_i) and a write port.
// When both ports address the same word in one cycle the read returns the old
// contents (read-before-write), which is what makes the buffer act as a
// one-line delay when read and written at the same column.
// Storage is deliberately not reset.
//   clk        : clock
//   rd_en_i    : capture mem[rd_addr_i] into rd_data_o
//   rd_addr_i  : read column
//   rd_data_o  : registered read data (holds while rd_en_i is low)
//   wr_en_i    : write wr_data_i to mem[wr_addr_i]
//   wr_addr_i  : write column
//   wr_data_i  : write data
module sobel_line_buf #(
    parameter int DEPTH = 320,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

endmodule

// File: rtl/sobel_grad_sq.sv
// Streaming 3x3 Sobel stage: raster-order pixels in, squared scaled gradients
// (gx_s^2, gy_s^2) out for every interior pixel of the frame.
// Build option: define SOBEL_SAT_EN to clamp gradients to +-255 instead of
// scaling them by an arithmetic shift of 2.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   pix_in    : unsigned pixel
//   pix_valid : pix_in valid this cycle
//   pix_sof   : with pix_valid, marks pixel (0,0) of a frame
//   sqrx/sqry : gx_s*gx_s / gy_s*gy_s, hold between results
//   sq_valid  : one-cycle pulse per interior-pixel result
//   sq_last   : with sq_valid, result for the last interior pixel of the frame
// Handshake: a pixel is transferred on every cycle pix_valid is high; there is
// no backpressure and idle cycles may appear anywhere. sq_valid is a
// single-cycle qualifier with no ready; the consumer must take it when high.
module sobel_grad_sq
    import sobel_pkg::*;
#(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             pix_sof,
    output logic [SQ_W-1:0]  sqrx,
    output logic [SQ_W-1:0]  sqry,
    output logic             sq_valid,
    output logic             sq_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_e          state_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic [CW-1:0]   prev_c_q;
    logic            accept;
    logic [RW-1:0]   cur_r;
    logic [CW-1:0]   cur_c;
    logic            last_pix;
    logic            out_pos;

    // Position of the pixel on the bus; sof forces (0,0) from any state.
    always_comb begin
        accept = 1'b0;
        cur_r  = '0;
        cur_c  = '0;
        if (pix_valid) begin
            if (pix_sof) begin
                accept = 1'b1;
            end else if (state_q == RUN) begin
                accept = 1'b1;
                cur_r  = row_q;
                cur_c  = col_q;
            end
        end
    end

    assign last_pix = (cur_r == RW'(IMG_H - 1)) && (cur_c == CW'(IMG_W - 1));
    assign out_pos  = (cur_r >= RW'(2)) && (cur_c >= CW'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else if (accept) begin
            if (last_pix) begin
                state_q <= DONE;
                row_q   <= '0;
                col_q   <= '0;
            end else begin
                state_q <= RUN;
                if (cur_c == CW'(IMG_W - 1)) begin
                    col_q <= '0;
                    row_q <= cur_r + RW'(1);
                end else begin
                    col_q <= cur_c + CW'(1);
                    row_q <= cur_r;
                end
            end
        end
    end

    // lb1 holds row r-1. lb2 holds row r-2 and is fed from lb1's registered
    // read data one accepted pixel later, at the column that data came from;
    // that column is not read again until the next row, so the lag is safe.
    logic [PIX_W-1:0] lb1_rd;
    logic [PIX_W-1:0] lb2_rd;

    always_ff @(posedge clk) begin
        if (accept) prev_c_q <= cur_c;
    end

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb1 (
        .clk       (clk),
        .rd_en_i   (accept),
        .rd_addr_i (cur_c),
        .rd_data_o (lb1_rd),
        .wr_en_i   (accept),
        .wr_addr_i (cur_c),
        .wr_data_i (pix_in)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb2 (
        .clk       (clk),
        .rd_en_i   (accept),
        .rd_addr_i (cur_c),
        .rd_data_o (lb2_rd),
        .wr_en_i   (accept),
        .wr_addr_i (prev_c_q),
        .wr_data_i (lb1_rd)
    );

    // Stage 1: the newest window column is {lb2_rd, lb1_rd, pix_q}; the two
    // older columns shift through win_q. Everything advances only on accept.
    logic [PIX_W-1:0] pix_q;
    logic [PIX_W-1:0] col_cur [3];
    logic [PIX_W-1:0] win_q [3][2];
    logic             v1_q, last1_q;

    always_comb begin
        col_cur[0] = lb2_rd;
        col_cur[1] = lb1_rd;
        col_cur[2] = pix_q;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pix_q <= pix_in;
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= col_cur[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            v1_q    <= accept && out_pos;
            last1_q <= accept && last_pix;
        end
    end

    // Stage 2: gradients and scaling.
    logic signed [GX_W-1:0] ps [3][3];
    logic signed [GX_W-1:0] gx, gy;
    logic signed [GS_W-1:0] gxs, gys;
    logic signed [GS_W-1:0] gxs_q, gys_q;
    logic                   v2_q, last2_q;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ps[i][0] = GX_W'(win_q[i][0]);
            ps[i][1] = GX_W'(win_q[i][1]);
            ps[i][2] = GX_W'(col_cur[i]);
        end
        gx = '0;
        gy = '0;
        for (int i = 0; i < 3; i++) begin
            gx = gx + SOBEL_K[i] * (ps[i][2] - ps[i][0]);
            gy = gy + SOBEL_K[i] * (ps[2][i] - ps[0][i]);
        end
    end

`ifdef SOBEL_SAT_EN
    always_comb begin
        if (gx > GX_W'(SAT_LIM))       gxs = GS_W'(SAT_LIM);
        else if (gx < -GX_W'(SAT_LIM)) gxs = -GS_W'(SAT_LIM);
        else                           gxs = GS_W'(gx);
        if (gy > GX_W'(SAT_LIM))       gys = GS_W'(SAT_LIM);
        else if (gy < -GX_W'(SAT_LIM)) gys = -GS_W'(SAT_LIM);
        else                           gys = GS_W'(gy);
    end
`else
    // Arithmetic shift floors toward -inf; +-1020 maps into +-255.
    always_comb begin
        gxs = GS_W'(gx >>> SCALE_SHIFT);
        gys = GS_W'(gy >>> SCALE_SHIFT);
    end
`endif

    always_ff @(posedge clk) begin
        if (v1_q) begin
            gxs_q <= gxs;
            gys_q <= gys;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
        end else begin
            v2_q    <= v1_q;
            last2_q <= last1_q;
        end
    end

    // Stage 3: square via magnitude so the product stays unsigned and narrow.
    logic [GS_W-1:0] ax, ay;
    logic [SQ_W-1:0] sqx, sqy;

    always_comb begin
        ax  = gxs_q[GS_W-1] ? GS_W'(-gxs_q) : gxs_q;
        ay  = gys_q[GS_W-1] ? GS_W'(-gys_q) : gys_q;
        sqx = SQ_W'(ax) * SQ_W'(ax);
        sqy = SQ_W'(ay) * SQ_W'(ay);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_valid <= 1'b0;
            sq_last  <= 1'b0;
            sqrx     <= '0;
            sqry     <= '0;
        end else begin
            sq_valid <= v2_q;
            sq_last  <= v2_q & last2_q;
            if (v2_q) begin
                sqrx <= sqx;
                sqry <= sqy;
            end
        end
    end

endmodule
